// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: drives one byte transfer through a memory-mapped I2C
// controller over APB. It programs the prescaler, the address byte, the TX
// byte (writes only) and the command register, polls status until done,
// then fetches the RX byte on a successful read.
//
// Optional feature: define I2C_SEQ_TIMEOUT_EN to count status polls and abort
// after TIMEOUT polls without completion. The abort clears the core enable in
// the command register and raises timeout_o. Without the macro the block
// polls forever and timeout_o is tied low.
//
// Ports:
//   pclk_i, preset_n_i        clock, async active-low reset
//   start_i                   transfer request, sampled only when idle
//   dev_addr_i, rw_i, wdata_i transfer parameters, captured on accepted start
//   busy_o, done_o            transfer in progress / one-cycle completion
//   nack_o, timeout_o         error flags, held until the next accepted start
//   rdata_o                   received byte (updated on a successful read only)
//   psel_o .. pwdata_o        APB master request
//   prdata_i, pready_i        APB completer response
module i2c_xfer_sequencer #(
  parameter logic [7:0]  PRESCALER = 8'h04,
  parameter logic [7:0]  CMD_GO    = 8'h44,
  parameter int unsigned DONE_BIT  = 0,
  parameter int unsigned NACK_BIT  = 1,
  parameter int unsigned POLL_GAP  = 8,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        pclk_i,
  input  logic        preset_n_i,
  input  logic        start_i,
  input  logic [6:0]  dev_addr_i,
  input  logic        rw_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_o,
  output logic        timeout_o,
  output logic [7:0]  rdata_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  localparam int unsigned APB_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [2:0] DONE_IDX = 3'(DONE_BIT);
  localparam logic [2:0] NACK_IDX = 3'(NACK_BIT);

  localparam logic [APB_W-1:0] A_PRESC = 32'h0000_0000;
  localparam logic [APB_W-1:0] A_CMD   = 32'h0000_0001;
  localparam logic [APB_W-1:0] A_TX    = 32'h0000_0002;
  localparam logic [APB_W-1:0] A_RX    = 32'h0000_0003;
  localparam logic [APB_W-1:0] A_ADDR  = 32'h0000_0004;
  localparam logic [APB_W-1:0] A_STAT  = 32'h0000_0005;

  typedef enum logic [3:0] {
    IDLE, W_PRESC, W_ADDR, W_TX, W_CMD, POLL, GAP, R_RX, FIN
  } state_t;

  state_t             state_q, state_n;
  logic               psel_q, psel_n, penable_q, penable_n, pwrite_q, pwrite_n;
  logic [APB_W-1:0]   paddr_q, paddr_n, pwdata_q, pwdata_n;
  logic               busy_q, busy_n, done_q, done_n, nack_q, nack_n;
  logic [BYTE_W-1:0]  rdata_q, rdata_n;
  logic [6:0]         dev_q, dev_n;
  logic               rw_q, rw_n;
  logic [BYTE_W-1:0]  tx_q, tx_n;
  logic [7:0]         gap_q, gap_n;
  logic [BYTE_W-1:0]  stat_c;
  logic               aborting;
  logic               unused_bits;

  assign stat_c = prdata_i[BYTE_W-1:0];

`ifdef I2C_SEQ_TIMEOUT_EN
  logic             timeout_q, timeout_n;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_n;
  assign aborting    = timeout_q;
  assign timeout_o   = timeout_q;
  assign unused_bits = ^prdata_i[APB_W-1:BYTE_W];
`else
  assign aborting    = 1'b0;
  assign timeout_o   = 1'b0;
  assign unused_bits = ^{prdata_i[APB_W-1:BYTE_W], TIMEOUT, CNT_W[0]};
`endif

  // Next-state and next-output logic; every APB state walks setup -> access
  // -> (pready) completion, and the cycle after completion is always bus-idle.
  always_comb begin
    state_n   = state_q;
    psel_n    = psel_q;
    penable_n = penable_q;
    pwrite_n  = pwrite_q;
    paddr_n   = paddr_q;
    pwdata_n  = pwdata_q;
    nack_n    = nack_q;
    rdata_n   = rdata_q;
    dev_n     = dev_q;
    rw_n      = rw_q;
    tx_n      = tx_q;
    gap_n     = gap_q;
    busy_n    = 1'b0;
    done_n    = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
    timeout_n  = timeout_q;
    poll_cnt_n = poll_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          dev_n   = dev_addr_i;
          rw_n    = rw_i;
          tx_n    = wdata_i;
          nack_n  = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
          timeout_n  = 1'b0;
          poll_cnt_n = '0;
`endif
          state_n = W_PRESC;
          psel_n  = 1'b1;
        end
      end

      // POLL_GAP idle cycles on top of the mandatory post-access idle cycle
      GAP: begin
        if (gap_q == 8'd0) begin
          state_n = POLL;
          psel_n  = 1'b1;
        end else begin
          gap_n = gap_q - 8'd1;
        end
      end

      FIN: state_n = IDLE;

      W_PRESC, W_ADDR, W_TX, W_CMD, POLL, R_RX: begin
        if (!psel_q) begin
          psel_n = 1'b1;
        end else if (!penable_q) begin
          penable_n = 1'b1;
        end else if (pready_i) begin
          psel_n    = 1'b0;
          penable_n = 1'b0;
          case (state_q)
            W_PRESC: state_n = W_ADDR;
            W_ADDR:  state_n = rw_q ? W_CMD : W_TX;
            W_TX:    state_n = W_CMD;
            W_CMD:   state_n = aborting ? FIN : POLL;
            POLL: begin
`ifdef I2C_SEQ_TIMEOUT_EN
              poll_cnt_n = poll_cnt_q + 16'd1;
`endif
              if (stat_c[DONE_IDX]) begin
                nack_n  = stat_c[NACK_IDX];
                state_n = (rw_q && !stat_c[NACK_IDX]) ? R_RX : FIN;
              end else begin
                state_n = GAP;
                gap_n   = 8'(POLL_GAP);
`ifdef I2C_SEQ_TIMEOUT_EN
                if (poll_cnt_n == TIMEOUT) begin
                  timeout_n = 1'b1;
                  state_n   = W_CMD;
                end
`endif
              end
            end
            R_RX: begin
              rdata_n = stat_c;
              state_n = FIN;
            end
            default: state_n = IDLE;
          endcase
        end
      end

      default: begin
        state_n   = IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end
    endcase

    // Request fields are loaded on entry to setup and held through completion
    if (psel_n && !psel_q) begin
      case (state_n)
        W_PRESC: begin paddr_n = A_PRESC; pwrite_n = 1'b1; pwdata_n = {24'h0, PRESCALER}; end
        W_ADDR:  begin paddr_n = A_ADDR;  pwrite_n = 1'b1; pwdata_n = {24'h0, dev_q, rw_q}; end
        W_TX:    begin paddr_n = A_TX;    pwrite_n = 1'b1; pwdata_n = {24'h0, tx_q}; end
        W_CMD: begin
          paddr_n  = A_CMD;
          pwrite_n = 1'b1;
          pwdata_n = {24'h0, aborting ? (CMD_GO & 8'hBF) : CMD_GO};
        end
        POLL:    begin paddr_n = A_STAT;  pwrite_n = 1'b0; pwdata_n = '0; end
        R_RX:    begin paddr_n = A_RX;    pwrite_n = 1'b0; pwdata_n = '0; end
        default: ;
      endcase
    end

    busy_n = (state_n != IDLE) && (state_n != FIN);
    done_n = (state_n == FIN);
  end

  // State and output registers
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      rdata_q   <= '0;
      dev_q     <= '0;
      rw_q      <= 1'b0;
      tx_q      <= '0;
      gap_q     <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      timeout_q  <= 1'b0;
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_n;
      psel_q    <= psel_n;
      penable_q <= penable_n;
      pwrite_q  <= pwrite_n;
      paddr_q   <= paddr_n;
      pwdata_q  <= pwdata_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      nack_q    <= nack_n;
      rdata_q   <= rdata_n;
      dev_q     <= dev_n;
      rw_q      <= rw_n;
      tx_q      <= tx_n;
      gap_q     <= gap_n;
`ifdef I2C_SEQ_TIMEOUT_EN
      timeout_q  <= timeout_n;
      poll_cnt_q <= poll_cnt_n;
`endif
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign nack_o    = nack_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench for i2c_xfer_sequencer: the stimulus side derives the
// expected APB access list and transfer result from each request and queues
// them; an APB responder/monitor and a completion monitor pop and compare.
module tb_i2c_xfer_sequencer;

  localparam int unsigned G = 8;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TO = 3;
`else
  localparam int unsigned TO = 1000;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } apb_t;

  typedef struct {
    logic        nack;
    logic        tout;
    logic [7:0]  rdata;
    int unsigned start_cyc;
    int unsigned lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  dev = '0;
  logic        rw = 1'b0;
  logic [7:0]  wdata = '0;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        busy, done, nack, tout, psel, penable, pwrite;
  logic [7:0]  rdata;
  logic [31:0] paddr, pwdata;

  apb_t        apb_q[$];
  res_t        res_q[$];
  logic [7:0]  stat_q[$];
  logic [7:0]  rx_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned ws_cfg = 0;
  logic [7:0]  model_rdata = 8'h00;

  i2c_xfer_sequencer #(.TIMEOUT(16'(TO))) dut (
    .pclk_i(clk), .preset_n_i(rst_n), .start_i(start), .dev_addr_i(dev),
    .rw_i(rw), .wdata_i(wdata), .busy_o(busy), .done_o(done), .nack_o(nack),
    .timeout_o(tout), .rdata_o(rdata), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // APB completer with per-access wait states; also checks request stability
  initial begin : responder
    int unsigned stall;
    logic        comp_prev;
    logic [31:0] s_addr, s_data;
    logic        s_wr;
    apb_t        e;
    stall = 0; comp_prev = 1'b0; s_addr = '0; s_data = '0; s_wr = 1'b0;
    forever begin
      @(negedge clk);
      pready = 1'($urandom);
      prdata = $urandom;
      if (!rst_n) begin
        stall = 0;
        comp_prev = 1'b0;
      end else begin
        if (comp_prev) begin
          check("apb_idle_after_xfer", {30'b0, psel, penable}, 32'h0);
          comp_prev = 1'b0;
        end
        if (psel && !penable) begin
          s_addr = paddr; s_wr = pwrite; s_data = pwdata;
          check("pwdata_upper_zero", 32'(pwdata[31:8]), 32'h0);
        end else if (psel && penable) begin
          check("paddr_stable", paddr, s_addr);
          check("pwdata_stable", pwdata, s_data);
          check("pwrite_stable", 32'(pwrite), 32'(s_wr));
          if (stall < ws_cfg) begin
            pready = 1'b0;
            stall++;
          end else begin
            pready = 1'b1;
            stall = 0;
            comp_prev = 1'b1;
            if (!pwrite && paddr == 32'h5 && stat_q.size() > 0)
              prdata = {24'($urandom), stat_q.pop_front()};
            else if (!pwrite && paddr == 32'h3 && rx_q.size() > 0)
              prdata = {24'($urandom), rx_q.pop_front()};
            if (apb_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL apb_unexpected: got addr %h write %0d, expected no access", paddr, pwrite);
            end else begin
              e = apb_q.pop_front();
              check("apb_addr", paddr, e.addr);
              check("apb_write", 32'(pwrite), 32'(e.wr));
              if (e.wr) check("apb_wdata", pwdata, e.data);
            end
          end
        end
      end
    end
  end

  // Completion monitor
  initial begin : result_mon
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (res_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done_unexpected: got done_o=1, expected no completion");
        end else begin
          r = res_q.pop_front();
          check("nack_o", 32'(nack), 32'(r.nack));
          check("timeout_o", 32'(tout), 32'(r.tout));
          check("rdata_o", 32'(rdata), 32'(r.rdata));
          check("busy_at_done", 32'(busy), 32'h0);
          check("latency", 32'(cyc - r.start_cyc), 32'(r.lat));
        end
      end
    end
  end

  // Build expectations from the request, then present it; caller is at a negedge.
  task automatic issue_xfer(input logic [6:0] d, input logic r, input logic [7:0] w,
                            input int unsigned npoll, input logic nk, input logic [7:0] rx,
                            input int unsigned ws, input bit pulse);
    int unsigned nacc, polls;
    logic        timed;
    res_t        res;
    ws_cfg = ws;
    apb_q.push_back('{32'h0, 1'b1, 32'h04});
    apb_q.push_back('{32'h4, 1'b1, {24'h0, d, r}});
    nacc = 2;
    if (!r) begin
      apb_q.push_back('{32'h2, 1'b1, {24'h0, w}});
      nacc++;
    end
    apb_q.push_back('{32'h1, 1'b1, 32'h44});
    nacc++;
`ifdef I2C_SEQ_TIMEOUT_EN
    timed = (npoll > TO);
`else
    timed = 1'b0;
`endif
    polls = timed ? TO : npoll;
    for (int i = 0; i < int'(polls); i++) begin
      apb_q.push_back('{32'h5, 1'b0, 32'h0});
      if (i == int'(npoll) - 1) stat_q.push_back({6'($urandom), nk, 1'b1});
      else                      stat_q.push_back({7'($urandom), 1'b0});
      nacc++;
    end
    res.nack = timed ? 1'b0 : nk;
    res.tout = timed;
    if (timed) begin
      apb_q.push_back('{32'h1, 1'b1, 32'h04});
      nacc++;
    end else if (r && !nk) begin
      apb_q.push_back('{32'h3, 1'b0, 32'h0});
      rx_q.push_back(rx);
      model_rdata = rx;
      nacc++;
    end
    res.rdata = model_rdata;
    res.lat = nacc * (3 + ws) + (polls - 1) * G;
    start = 1'b1; dev = d; rw = r; wdata = w;
    res.start_cyc = cyc;
    res_q.push_back(res);
    @(negedge clk);
    start = 1'b0; dev = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
    if (pulse) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int unsigned k;
    k = 0;
    while (res_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (res_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_wait: got no done_o within %0d cycles, expected completion", k);
      res_q.delete(); apb_q.delete(); stat_q.delete(); rx_q.delete();
    end
    check("apb_leftover", 32'(apb_q.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic run_xfer(input logic [6:0] d, input logic r, input logic [7:0] w,
                          input int unsigned npoll, input logic nk, input logic [7:0] rx,
                          input int unsigned ws, input bit pulse);
    @(negedge clk);
    issue_xfer(d, r, w, npoll, nk, rx, ws, pulse);
    wait_done();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned k;
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_nack", 32'(nack), 32'h0);
    check("rst_timeout", 32'(tout), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);

    // Start on the very first edge after release: minimum write latency
    @(negedge clk);
    rst_n = 1'b1;
    issue_xfer(7'h50, 1'b0, 8'hA5, 1, 1'b0, 8'h00, 0, 1'b0);
    wait_done();
    run_xfer(7'h50, 1'b1, 8'h00, 3, 1'b0, 8'h3C, 0, 1'b0);
    run_xfer(7'h50, 1'b1, 8'h11, 1, 1'b1, 8'h99, 0, 1'b0);
    run_xfer(7'h2B, 1'b0, 8'h5A, 2, 1'b0, 8'h00, 4, 1'b1);
    run_xfer(7'h61, 1'b1, 8'h00, 1, 1'b0, 8'hC4, 4, 1'b1);
`ifdef I2C_SEQ_TIMEOUT_EN
    run_xfer(7'h50, 1'b1, 8'h00, TO + 2, 1'b0, 8'h00, 0, 1'b0);
`endif

    // Reset asserted while the command write is stalled in its access cycle
    @(negedge clk);
    issue_xfer(7'h33, 1'b0, 8'hC3, 1, 1'b0, 8'h00, 4, 1'b0);
    k = 0;
    while (!(psel && penable && pwrite && paddr == 32'h1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reach_cmd_access", 32'(psel && penable && paddr == 32'h1), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_psel", 32'(psel), 32'h0);
    check("mid_rst_penable", 32'(penable), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    res_q.delete(); apb_q.delete(); stat_q.delete(); rx_q.delete();
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue_xfer(7'h50, 1'b1, 8'h00, 2, 1'b0, 8'hE7, 0, 1'b0);
    wait_done();

    for (int i = 0; i < 24; i++) begin
      run_xfer(7'($urandom), 1'($urandom), 8'($urandom), $urandom_range(1, 4),
               1'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
